usb_crc16_tx: RTL and testbench
===============================

Name: usb_crc16_tx

Overview:
- Transmit-side USB CRC-16 generator/appender for the bridge's USB data-packet TX path.
- Sits between the TX packet serializer and the bit stuffer/NRZI encoder.
- Passes payload bits through while accumulating CRC-16, then appends the 16 complemented CRC bits.
- Paces on the downstream bit strobe, so bit-stuff stalls are tolerated.

Parameters:
POLY, 16'h8005, generator polynomial x^16+x^15+x^2+1
INIT, 16'hFFFF, CRC register seed loaded on start

Ports:
clk  input  1  system clock
n_rst  input  1  reset; synchronous, active-high (1 = reset on next clk edge)
start  input  1  one-cycle pulse: seed CRC, begin packet
shift_en  input  1  bit strobe from TX timer; one bit consumed/produced per high cycle
d_in  input  1  payload bit (wire order), valid when shift_en=1 in DATA
data_end  input  1  pulse: payload finished, begin CRC append
abort  input  1  drop current packet, return to IDLE
d_out  output  1  serial bit to stuffer: d_in in DATA, complemented CRC bit in CRC, 1 otherwise
crc_active  output  1  high while CRC bits are being emitted
busy  output  1  high in DATA or CRC
done  output  1  one-cycle pulse after the 16th CRC bit is shifted out
crc_value  output  16  current CRC register contents (debug/verification)

Behaviour:
- Reset: synchronous, active-high.
  - State=IDLE, crc register=INIT, bit counter=0.
  - d_out=1, crc_active=0, busy=0, done=0, crc_value=16'hFFFF.
  - Reset has priority over every other input, including mid-DATA and mid-CRC.
- States: IDLE, DATA, CRC.
  - IDLE -> DATA on start; crc <= INIT.
  - DATA -> CRC on data_end.
  - CRC -> IDLE after the 16th shift_en in CRC; done=1 in the cycle following that edge.
- DATA, per shift_en:
  - fb = d_in ^ crc[15].
  - crc <= {crc[14:0],1'b0} ^ (fb ? POLY : 16'h0).
  - d_out = d_in combinationally.
- data_end and shift_en in the same cycle: the bit is consumed (CRC updated with it), then the state moves to CRC. The CRC starts from the updated value.
- data_end on the first DATA cycle with no bits sent (empty packet): CRC = ~INIT = 16'h0000.
- CRC state:
  - d_out = ~crc[15] combinationally.
  - Each shift_en: crc <= {crc[14:0],1'b1}; counter +1.
  - The MSB of the complemented remainder goes out first. Exactly 16 bits.
  - Counter is 4-bit. Exit when counter==15 and shift_en=1; counter then wraps to 0.
- No shift_en: state, counter and crc hold. d_out stays stable for the whole stall.
- shift_en in IDLE is ignored. d_in and data_end are ignored outside DATA.
- start while busy: restart. crc <= INIT, counter <= 0, state=DATA, no done pulse.
- abort: any state -> IDLE, no done pulse, crc <= INIT. If abort and start are both high, abort wins.
- Latency: zero-cycle passthrough of d_in. The CRC append immediately follows the last data bit with no gap strobe.
- Residual property: running the receiver-side CRC-16 over data plus the appended CRC leaves the USB residual 16'h800D.

Test Plan:
- Reset mid-CRC: assert n_rst=1 for one edge during the 5th CRC bit -> IDLE, d_out=1, busy=0, crc_active=0, crc_value=16'hFFFF, no done.
- Empty packet: start, then data_end, then 16 strobes -> d_out=0 for all 16 bits, done pulses once, busy falls the same cycle as done rises.
- Single data bit 1: bit=1, then data_end -> crc_value=16'hFFFE, emitted CRC bits 0000_0000_0000_0001.
- Single data bit 0 with data_end asserted on the same shift_en cycle -> crc_value=16'h7FFB, emitted bits 1000_0000_0000_0100.
- Stalls: address 8'b11001111 with random 0-3 cycle gaps between strobes -> emitted CRC identical to the no-gap run. Feeding all 24 bits into a reference checker yields 16'h800D.
- Abort/restart: start while in DATA -> crc_value=16'hFFFF next cycle. abort in CRC -> IDLE, no done. abort+start together -> IDLE.

Source files
------------

// File: rtl/usb_crc16_tx_if.sv
// Serial TX-path bundle between the packet serializer, the CRC-16 appender and the bit stuffer.
interface usb_crc16_tx_if;
  logic        start;
  logic        shift_en;
  logic        d_in;
  logic        data_end;
  logic        abort;
  logic        d_out;
  logic        crc_active;
  logic        busy;
  logic        done;
  logic [15:0] crc_value;

  modport master (
    output start, shift_en, d_in, data_end, abort,
    input  d_out, crc_active, busy, done, crc_value
  );

  modport slave (
    input  start, shift_en, d_in, data_end, abort,
    output d_out, crc_active, busy, done, crc_value
  );
endinterface

// File: rtl/usb_crc16_tx.sv
// USB CRC-16 generator/appender: passes payload bits through, then shifts out the
// complemented CRC MSB first, paced by the downstream bit strobe.
module usb_crc16_tx #(
  parameter logic [15:0] POLY = 16'h8005,
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic           clk,
  input  logic           n_rst,
  usb_crc16_tx_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [15:0] crc_r;
  logic [15:0] crc_nxt_s;
  logic [3:0]  cnt_r;
  logic [3:0]  cnt_nxt_s;
  logic        done_r;
  logic        done_nxt_s;
  logic        d_out_s;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb       = bit_in ^ crc[15];
    crc_step = {crc[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
  endfunction

  // State, CRC register, append counter and done pulse registers.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_r <= ST_IDLE;
      crc_r   <= INIT;
      cnt_r   <= 4'd0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      crc_r   <= crc_nxt_s;
      cnt_r   <= cnt_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  // Next-state logic; abort beats start, and both beat normal sequencing.
  always_comb begin
    state_nxt_s = state_r;
    crc_nxt_s   = crc_r;
    cnt_nxt_s   = cnt_r;
    done_nxt_s  = 1'b0;
    if (bus.abort) begin
      state_nxt_s = ST_IDLE;
      crc_nxt_s   = INIT;
      cnt_nxt_s   = 4'd0;
    end else if (bus.start) begin
      state_nxt_s = ST_DATA;
      crc_nxt_s   = INIT;
      cnt_nxt_s   = 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_DATA: begin
          // A bit strobed together with data_end is still folded into the CRC.
          if (bus.shift_en) begin
            crc_nxt_s = crc_step(crc_r, bus.d_in);
          end else begin
            crc_nxt_s = crc_r;
          end
          if (bus.data_end) begin
            state_nxt_s = ST_CRC;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end
        ST_CRC: begin
          if (bus.shift_en) begin
            crc_nxt_s = {crc_r[14:0], 1'b1};
            cnt_nxt_s = cnt_r + 4'd1;
            if (cnt_r == 4'd15) begin
              state_nxt_s = ST_IDLE;
              done_nxt_s  = 1'b1;
            end else begin
              state_nxt_s = ST_CRC;
            end
          end else begin
            state_nxt_s = ST_CRC;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          crc_nxt_s   = INIT;
          cnt_nxt_s   = 4'd0;
        end
      endcase
    end
  end

  // Serial output mux; payload passes through with no register stage.
  always_comb begin
    d_out_s = 1'b1;
    case (state_r)
      ST_IDLE: d_out_s = 1'b1;
      ST_DATA: d_out_s = bus.d_in;
      ST_CRC:  d_out_s = ~crc_r[15];
      default: d_out_s = 1'b1;
    endcase
  end

  assign bus.d_out      = d_out_s;
  assign bus.busy       = (state_r != ST_IDLE);
  assign bus.crc_active = (state_r == ST_CRC);
  assign bus.done       = done_r;
  assign bus.crc_value  = crc_r;

endmodule

// File: tb/tb_usb_crc16_tx.sv
// Self-checking bench for usb_crc16_tx: polynomial-division reference model, per-cycle
// compare of every output, plus literal checks from hand-worked vectors.
module tb_usb_crc16_tx;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  usb_crc16_tx_if bus ();

  usb_crc16_tx dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: phase 0 idle, 1 data, 2 crc append.
  int          m_phase = 0;
  bit          m_bits[$];
  logic [15:0] m_final = 16'h0000;
  int          m_k = 0;
  bit          m_done = 1'b0;
  bit          m_known = 1'b0;

  logic        e_dout, e_busy, e_act, e_done;
  logic [15:0] e_crc;
  logic [15:0] cap;
  logic [15:0] cap_ref;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // CRC register after a bit stream = (INIT*x^n + M(x)*x^16) mod P, by long division.
  function automatic logic [15:0] crc_of(input bit q[$]);
    logic [63:0] v;
    int n;
    n = q.size();
    v = 64'(16'hFFFF) << n;
    for (int i = 0; i < n; i++) begin
      if (q[i]) v = v ^ (64'd1 << (n - 1 - i + 16));
    end
    for (int i = 63; i >= 16; i--) begin
      if (v[i]) v = v ^ (64'h0000_0000_0001_8005 << (i - 16));
    end
    return v[15:0];
  endfunction

  always @(negedge clk) begin
    if (m_known) begin
      chk("d_out", 32'(bus.d_out), 32'(e_dout));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("crc_active", 32'(bus.crc_active), 32'(e_act));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("crc_value", 32'(bus.crc_value), 32'(e_crc));
    end
  end

  task automatic step(input bit rst, input bit st, input bit se, input bit din,
                      input bit de, input bit ab);
    n_rst        = rst;
    bus.start    = st;
    bus.shift_en = se;
    bus.d_in     = din;
    bus.data_end = de;
    bus.abort    = ab;
    case (m_phase)
      1: begin
        e_dout = din; e_busy = 1'b1; e_act = 1'b0; e_crc = crc_of(m_bits);
      end
      2: begin
        e_dout = ~m_final[15 - m_k]; e_busy = 1'b1; e_act = 1'b1;
        e_crc  = 16'((32'(m_final) << m_k) | ((32'd1 << m_k) - 32'd1));
      end
      default: begin
        e_dout = 1'b1; e_busy = 1'b0; e_act = 1'b0; e_crc = 16'hFFFF;
      end
    endcase
    e_done = m_done;
    @(negedge clk);
    if (m_phase == 2 && se && !rst && !ab && !st) cap = {cap[14:0], bus.d_out};
    @(posedge clk);
    m_done = 1'b0;
    if (rst) begin
      m_phase = 0; m_bits.delete(); m_known = 1'b1;
    end else if (ab) begin
      m_phase = 0; m_bits.delete();
    end else if (st) begin
      m_phase = 1; m_bits.delete();
    end else if (m_phase == 1) begin
      if (se) m_bits.push_back(din);
      if (de) begin
        m_final = crc_of(m_bits); m_phase = 2; m_k = 0;
      end
    end else if (m_phase == 2 && se) begin
      m_k++;
      if (m_k == 16) begin
        m_phase = 0; m_done = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_bits(input logic [31:0] data, input int n, input int max_gap);
    for (int i = 0; i < n; i++) begin
      int g;
      g = $urandom_range(0, max_gap);
      for (int j = 0; j < g; j++) step(1'b0, 1'b0, 1'b0, data[n - 1 - i], 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, data[n - 1 - i], 1'b0, 1'b0);
    end
  endtask

  task automatic send_crc(input int max_gap);
    cap = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      int g;
      g = $urandom_range(0, max_gap);
      for (int j = 0; j < g; j++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("done_once", 32'(bus.done), 32'd0);
  endtask

  task automatic chk_residual(input string name);
    bit q[$];
    q = m_bits;
    for (int i = 15; i >= 0; i--) q.push_back(cap[i]);
    chk(name, 32'(crc_of(q)), 32'h0000_800D);
  endtask

  initial begin
    bus.start = 1'b0; bus.shift_en = 1'b0; bus.d_in = 1'b0;
    bus.data_end = 1'b0; bus.abort = 1'b0; n_rst = 1'b1;

    // Reset, then strobes / data / data_end in IDLE must be ignored.
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("reset_crc", 32'(bus.crc_value), 32'h0000_FFFF);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("idle_ignore", 32'(bus.crc_value), 32'h0000_FFFF);

    // Empty packet: complemented INIT is all zeros.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("empty_crc", 32'(bus.crc_value), 32'h0000_FFFF);
    send_crc(0);
    chk("empty_bits", 32'(cap), 32'h0000_0000);

    // Single bit 1, data_end on the following cycle.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("one_crc", 32'(bus.crc_value), 32'h0000_FFFE);
    send_crc(0);
    chk("one_bits", 32'(cap), 32'h0000_0001);

    // Single bit 0 with data_end on the same strobe.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("zero_crc", 32'(bus.crc_value), 32'h0000_7FFB);
    send_crc(0);
    chk("zero_bits", 32'(cap), 32'h0000_8004);

    // Address byte without gaps, then with random stalls.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h0000_00CF, 8, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_crc(0);
    cap_ref = cap;
    chk_residual("residual_nogap");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h0000_00CF, 8, 3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_crc(3);
    chk("stall_same_crc", 32'(cap), 32'(cap_ref));
    chk_residual("residual_stall");

    // Reset during the 5th CRC bit.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h0000_000B, 4, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    chk("rst_mid_crc", 32'(bus.crc_value), 32'h0000_FFFF);
    chk("rst_mid_dout", 32'(bus.d_out), 32'd1);
    idle(3);

    // Restart while in DATA, then complete the packet.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h0000_0005, 3, 1);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart_crc", 32'(bus.crc_value), 32'h0000_FFFF);
    chk("restart_busy", 32'(bus.busy), 32'd1);
    send_bits(32'h0000_A5C3, 16, 1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    send_crc(1);
    chk_residual("residual_restart");

    // Abort in CRC: back to IDLE, no done.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h0000_0002, 2, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("abort_crc_busy", 32'(bus.busy), 32'd0);
    chk("abort_crc_val", 32'(bus.crc_value), 32'h0000_FFFF);
    idle(3);

    // abort together with start: abort wins, in DATA and in IDLE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_bits(32'h0000_0001, 1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_start_data", 32'(bus.busy), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("abort_start_idle", 32'(bus.busy), 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
